// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, device-clocked frame, ack.
// Define PS2_TX_RETRY_EN to resend the byte once after a nack.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       kclk_in,
    input  logic       kdata_in,
    output logic       kclk_oe,
    output logic       kdata_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err_timeout
);

    localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_START, S_DATA,
        S_PARITY, S_STOP, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t state, state_n;

    logic [1:0]            clk_sync, dat_sync;
    logic [FILTER_LEN-1:0] clk_hist, dat_hist;
    logic                  clk_f, dat_f, clk_f_q;
    logic                  fall, rise;

    logic [7:0]    data_q, data_n;
    logic          par_q, par_n;
    logic [2:0]    idx_q, idx_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          kclk_oe_n, kdata_oe_n, done_n, ack_n, tmo_n;
    logic          in_frame, tmo_hit;
`ifdef PS2_TX_RETRY_EN
    logic          retry_q, retry_n;
`endif

    // Lines idle high, so synchronizers and filters reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_hist <= '1;
            dat_hist <= '1;
            clk_f    <= 1'b1;
            dat_f    <= 1'b1;
            clk_f_q  <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], kclk_in};
            dat_sync <= {dat_sync[0], kdata_in};
            clk_hist <= (clk_hist << 1) | FILTER_LEN'(clk_sync[1]);
            dat_hist <= (dat_hist << 1) | FILTER_LEN'(dat_sync[1]);
            if (&clk_hist)       clk_f <= 1'b1;
            else if (~|clk_hist) clk_f <= 1'b0;
            if (&dat_hist)       dat_f <= 1'b1;
            else if (~|dat_hist) dat_f <= 1'b0;
            clk_f_q  <= clk_f;
        end
    end

    assign fall = clk_f_q & ~clk_f;
    assign rise = ~clk_f_q & clk_f;

    assign tx_ready = (state == S_IDLE);
    assign busy     = ~tx_ready;

    assign in_frame = (state == S_START) || (state == S_DATA) ||
                      (state == S_PARITY) || (state == S_STOP) ||
                      (state == S_ACK) || (state == S_WAIT_IDLE);
    assign tmo_hit  = in_frame && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_n    = state;
        data_n     = data_q;
        par_n      = par_q;
        idx_n      = idx_q;
        cnt_n      = cnt_q + CW'(1);
        kclk_oe_n  = kclk_oe;
        kdata_oe_n = kdata_oe;
        done_n     = 1'b0;
        ack_n      = ack_ok;
        tmo_n      = err_timeout;
`ifdef PS2_TX_RETRY_EN
        retry_n    = retry_q;
`endif
        unique case (state)
            S_IDLE: begin
                kclk_oe_n  = 1'b0;
                kdata_oe_n = 1'b0;
                cnt_n      = '0;
                if (tx_valid) begin
                    data_n    = tx_data;
                    par_n     = ~^tx_data;
                    idx_n     = '0;
                    ack_n     = 1'b0;
                    tmo_n     = 1'b0;
`ifdef PS2_TX_RETRY_EN
                    retry_n   = 1'b0;
`endif
                    kclk_oe_n = 1'b1;
                    state_n   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                kclk_oe_n  = 1'b1;
                kdata_oe_n = 1'b0;
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                    kdata_oe_n = 1'b1;
                    cnt_n      = '0;
                    state_n    = S_REQ;
                end
            end
            S_REQ: begin
                kclk_oe_n  = 1'b0;
                kdata_oe_n = 1'b1;
                cnt_n      = '0;
                state_n    = S_START;
            end
            S_START: begin
                if (fall) begin
                    kdata_oe_n = ~data_q[0];
                    idx_n      = '0;
                    state_n    = S_DATA;
                end
            end
            S_DATA: begin
                if (fall) begin
                    if (idx_q != 3'd7) begin
                        idx_n      = idx_q + 3'd1;
                        kdata_oe_n = ~data_q[idx_q + 3'd1];
                    end else begin
                        kdata_oe_n = ~par_q;
                        state_n    = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    kdata_oe_n = 1'b0;
                    state_n    = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) state_n = S_ACK;
            end
            S_ACK: begin
                if (rise) begin
                    ack_n   = ~dat_f;
                    state_n = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_f && dat_f) begin
`ifdef PS2_TX_RETRY_EN
                    if (!retry_q && !ack_ok) begin
                        retry_n   = 1'b1;
                        idx_n     = '0;
                        cnt_n     = '0;
                        kclk_oe_n = 1'b1;
                        state_n   = S_INHIBIT;
                    end else begin
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end
`else
                    done_n  = 1'b1;
                    state_n = S_IDLE;
`endif
                end
            end
            default: begin
                kclk_oe_n  = 1'b0;
                kdata_oe_n = 1'b0;
                state_n    = S_IDLE;
            end
        endcase
        // Timeout overrides any edge handled above.
        if (tmo_hit) begin
            kclk_oe_n  = 1'b0;
            kdata_oe_n = 1'b0;
            tmo_n      = 1'b1;
            ack_n      = 1'b0;
            done_n     = 1'b1;
            state_n    = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            data_q      <= '0;
            par_q       <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
            kclk_oe     <= 1'b0;
            kdata_oe    <= 1'b0;
            done        <= 1'b0;
            ack_ok      <= 1'b0;
            err_timeout <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q     <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            data_q      <= data_n;
            par_q       <= par_n;
            idx_q       <= idx_n;
            cnt_q       <= cnt_n;
            kclk_oe     <= kclk_oe_n;
            kdata_oe    <= kdata_oe_n;
            done        <= done_n;
            ack_ok      <= ack_n;
            err_timeout <= tmo_n;
`ifdef PS2_TX_RETRY_EN
            retry_q     <= retry_n;
`endif
        end
    end

endmodule
